// File: rtl/saturn_jump_decoder_pkg.sv
// Shared definitions for the Saturn jump/return decoder: FSM states,
// jump length codes and the opcode nibbles it recognises.
package saturn_jump_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP0,
        ST_OP8,
        ST_OFFS,
        ST_SKIP
    } state_t;

    // Offset nibble count delivered to the PC block is length + 1
    localparam logic [2:0] JMP_NONE = 3'd0;
    localparam logic [2:0] JMP_REL2 = 3'd1;
    localparam logic [2:0] JMP_REL3 = 3'd2;
    localparam logic [2:0] JMP_REL4 = 3'd3;
    localparam logic [2:0] JMP_ABS5 = 3'd4;

    localparam logic [3:0] OP_RTN_BLK = 4'h0;
    localparam logic [3:0] OP_GOC     = 4'h4;
    localparam logic [3:0] OP_GONC    = 4'h5;
    localparam logic [3:0] OP_GOTO    = 4'h6;
    localparam logic [3:0] OP_GOSUB   = 4'h7;
    localparam logic [3:0] OP_BLK8    = 4'h8;

    localparam logic [3:0] OP_GOLONG  = 4'hC;
    localparam logic [3:0] OP_GOVLNG  = 4'hD;
    localparam logic [3:0] OP_GOSUBL  = 4'hE;
    localparam logic [3:0] OP_GOSBVL  = 4'hF;

endpackage

// File: rtl/saturn_jump_decoder.sv
// Saturn jump/return family decoder feeding the PC/RSTK block.
// Define SATURN_RTN_FLAGS_EN to decode the RTNSXM/RTNSC/RTNCC side effects.
module saturn_jump_decoder
    import saturn_jump_decoder_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_bus_busy,
    input  logic        i_exec_unit_busy,
    input  logic        i_instr_start,
    input  logic [3:0]  i_nibble,
    input  logic        i_carry,
    output logic        o_jump_instr,
    output logic [2:0]  o_jump_length,
    output logic        o_push_pc,
    output logic        o_block_0x,
    output logic        o_rtn_instr,
    output logic        o_set_carry,
    output logic        o_clr_carry,
    output logic        o_set_xm,
    output logic        o_busy
);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       jump_nxt;
    logic [2:0] length_nxt;
    logic       push_nxt;
    logic       block_nxt;
    logic       rtn_nxt;
    logic       set_carry_nxt;
    logic       clr_carry_nxt;
    logic       set_xm_nxt;
    logic       taken;
    logic       step;

    assign step   = i_clk_en & ~i_bus_busy & ~i_exec_unit_busy & i_phases[2];
    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            cnt           <= 3'd0;
            o_jump_instr  <= 1'b0;
            o_jump_length <= JMP_NONE;
            o_push_pc     <= 1'b0;
            o_block_0x    <= 1'b0;
            o_rtn_instr   <= 1'b0;
            o_set_carry   <= 1'b0;
            o_clr_carry   <= 1'b0;
            o_set_xm      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            o_jump_instr  <= jump_nxt;
            o_jump_length <= length_nxt;
            o_push_pc     <= push_nxt;
            o_block_0x    <= block_nxt;
            o_rtn_instr   <= rtn_nxt;
            o_set_carry   <= set_carry_nxt;
            o_clr_carry   <= clr_carry_nxt;
            o_set_xm      <= set_xm_nxt;
        end
    end

    // Outside a step every register holds; the IDLE step wipes all pulses.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        jump_nxt      = o_jump_instr;
        length_nxt    = o_jump_length;
        push_nxt      = o_push_pc;
        block_nxt     = o_block_0x;
        rtn_nxt       = o_rtn_instr;
        set_carry_nxt = o_set_carry;
        clr_carry_nxt = o_clr_carry;
        set_xm_nxt    = o_set_xm;
        taken         = 1'b0;
        if (step) begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt       = 3'd0;
                    jump_nxt      = 1'b0;
                    length_nxt    = JMP_NONE;
                    push_nxt      = 1'b0;
                    block_nxt     = 1'b0;
                    rtn_nxt       = 1'b0;
                    set_carry_nxt = 1'b0;
                    clr_carry_nxt = 1'b0;
                    set_xm_nxt    = 1'b0;
                    if (i_instr_start) begin
                        case (i_nibble)
                            OP_RTN_BLK: begin
                                state_nxt = ST_OP0;
                                block_nxt = 1'b1;
                            end
                            OP_GOC, OP_GONC: begin
                                taken = (i_nibble == OP_GOC) ? i_carry : ~i_carry;
                                if (taken) begin
                                    state_nxt  = ST_OFFS;
                                    jump_nxt   = 1'b1;
                                    length_nxt = JMP_REL2;
                                end else begin
                                    state_nxt = ST_SKIP;
                                    cnt_nxt   = 3'd1;
                                end
                            end
                            OP_GOTO, OP_GOSUB: begin
                                state_nxt  = ST_OFFS;
                                jump_nxt   = 1'b1;
                                length_nxt = JMP_REL3;
                                push_nxt   = (i_nibble == OP_GOSUB);
                            end
                            OP_BLK8: state_nxt = ST_OP8;
                            default: state_nxt = ST_IDLE;
                        endcase
                    end
                end
                ST_OP0: begin
                    state_nxt = ST_IDLE;
                    block_nxt = 1'b0;
                    if (i_nibble[3:2] == 2'b00) begin
                        rtn_nxt = 1'b1;
`ifdef SATURN_RTN_FLAGS_EN
                        set_xm_nxt    = (i_nibble == 4'h0);
                        set_carry_nxt = (i_nibble == 4'h2);
                        clr_carry_nxt = (i_nibble == 4'h3);
`endif
                    end
                end
                ST_OP8: begin
                    state_nxt = ST_IDLE;
                    case (i_nibble)
                        OP_GOLONG, OP_GOVLNG, OP_GOSUBL, OP_GOSBVL: begin
                            state_nxt  = ST_OFFS;
                            jump_nxt   = 1'b1;
                            length_nxt = i_nibble[0] ? JMP_ABS5 : JMP_REL4;
                            push_nxt   = i_nibble[1];
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
                ST_OFFS: begin
                    // jump_instr drops only after the last offset nibble is sampled
                    if (cnt == o_jump_length) begin
                        state_nxt  = ST_IDLE;
                        cnt_nxt    = 3'd0;
                        jump_nxt   = 1'b0;
                        push_nxt   = 1'b0;
                        length_nxt = JMP_NONE;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                ST_SKIP: begin
                    if (cnt == 3'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

`ifdef SIM
    always_ff @(posedge i_clk) begin
        if (!i_reset && step && (state != state_nxt)) begin
            $display("[saturn_jump_decoder] cyc=%0d ph=%0d %s -> %s nib=%h",
                     i_cycle_ctr, i_phase, state.name(), state_nxt.name(), i_nibble);
        end
    end
`endif

    logic unused;
    assign unused = &{1'b0, i_phase, i_cycle_ctr, i_phases[3], i_phases[1:0]};

endmodule
